// File: rtl/if_stage_if.sv
// Instruction-memory read port: level request held until a completion ack.
// The fetch stage drives the master side; the memory model drives the slave side.
interface if_stage_if;
    // imem_req is raised with imem_addr and both stay put until the cycle imem_ack=1;
    // that cycle is the transfer, and imem_rdata is only meaningful while imem_ack=1.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Fetches over a req/ack port, obeys decode freeze and execute branch redirect/flush.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           freeze,
    input  logic           branch_taken,
    input  logic [31:0]    branch_addr,
    if_stage_if.master     imem,
    output logic [31:0]    instruction,
    output logic [31:0]    pc_out,
    output logic           valid,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic [31:0] r_pend_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [31:0] w_hold_pc_nxt;
    logic [31:0] w_pend_addr_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_out_nxt;
    logic        w_valid_nxt;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_pc_inc;

    // Request is gated by reset so the memory never sees a fetch during reset.
    assign w_req    = rst && (r_state != S_HOLD);
    assign w_ack    = imem.imem_ack && w_req;
    assign w_pc_inc = r_pc + PC_STEP;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    assign instruction = r_instr;
    assign pc_out      = r_pc_out;
    assign valid       = r_valid;
    assign dbg_state   = r_state;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_pend_addr_nxt  = r_pend_addr;
        w_instr_nxt      = r_instr;
        w_pc_out_nxt     = r_pc_out;
        w_valid_nxt      = r_valid;

        case (r_state)
            S_REQ: begin
                if (branch_taken) begin
                    w_instr_nxt  = 32'd0;
                    w_pc_out_nxt = 32'd0;
                    w_valid_nxt  = 1'b0;
                    if (w_ack) begin
                        w_pc_nxt = branch_addr;
                    end else begin
                        // The outstanding fetch cannot be withdrawn; remember the target.
                        w_pend_addr_nxt = branch_addr;
                        w_state_nxt     = S_DROP;
                    end
                end else if (w_ack) begin
                    w_pc_nxt = w_pc_inc;
                    if (freeze) begin
                        w_hold_instr_nxt = imem.imem_rdata;
                        w_hold_pc_nxt    = w_pc_inc;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_instr_nxt  = imem.imem_rdata;
                        w_pc_out_nxt = w_pc_inc;
                        w_valid_nxt  = 1'b1;
                    end
                end else if (!freeze) begin
                    w_instr_nxt = 32'd0;
                    w_valid_nxt = 1'b0;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    w_instr_nxt  = 32'd0;
                    w_pc_out_nxt = 32'd0;
                    w_valid_nxt  = 1'b0;
                    w_pc_nxt     = branch_addr;
                    w_state_nxt  = S_REQ;
                end else if (!freeze) begin
                    w_instr_nxt  = r_hold_instr;
                    w_pc_out_nxt = r_hold_pc;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_REQ;
                end
            end

            S_DROP: begin
                w_instr_nxt  = 32'd0;
                w_pc_out_nxt = 32'd0;
                w_valid_nxt  = 1'b0;
                if (w_ack) begin
                    // A redirect arriving with the ack is newer than the pending one.
                    w_pc_nxt    = branch_taken ? branch_addr : r_pend_addr;
                    w_state_nxt = S_REQ;
                end else if (branch_taken) begin
                    w_pend_addr_nxt = branch_addr;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_pend_addr  <= 32'd0;
            r_instr      <= 32'd0;
            r_pc_out     <= 32'd0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns the fetch address as data,
// with a programmable number of wait states before each ack.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;
    logic [1:0]  dbg_state;

    int total;
    int bad;
    int mem_wait;
    int mem_cnt;

    if_stage_if imem_bus ();

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem_bus),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .valid        (valid),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack once req has been held for mem_wait cycles, data = address.
    assign imem_bus.imem_ack   = imem_bus.imem_req && (mem_cnt == mem_wait);
    assign imem_bus.imem_rdata = imem_bus.imem_ack ? imem_bus.imem_addr : 32'hDEAD_BEEF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_cnt <= 0;
        else if (!imem_bus.imem_req || imem_bus.imem_ack) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int wait_states);
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        mem_wait     = wait_states;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset values
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; mem_wait = 0;
        #2;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pcout", pc_out, 32'd0);
        chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        // Zero-wait streaming
        do_reset(0);
        chk("zw_addr0", imem_bus.imem_addr, 32'd0);
        chk("zw_req0", {31'd0, imem_bus.imem_req}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("zw_valid", {31'd0, valid}, 32'd1);
            chk("zw_instr", instruction, 32'(4 * k));
            chk("zw_pcout", pc_out, 32'(4 * (k + 1)));
        end

        // Two wait states: two bubbles before each word
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 2; b++) begin
                step();
                chk("ws_bub_valid", {31'd0, valid}, 32'd0);
                chk("ws_bub_instr", instruction, 32'd0);
            end
            step();
            chk("ws_valid", {31'd0, valid}, 32'd1);
            chk("ws_instr", instruction, 32'(4 * k));
            chk("ws_pcout", pc_out, 32'(4 * (k + 1)));
        end

        // Freeze for 3 cycles on the ack of address 8
        do_reset(0);
        step();
        step();
        chk("fz_pre_pcout", pc_out, 32'd8);
        chk("fz_pre_addr", imem_bus.imem_addr, 32'd8);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fz_hold_pcout", pc_out, 32'd8);
            chk("fz_hold_instr", instruction, 32'd4);
            chk("fz_hold_valid", {31'd0, valid}, 32'd1);
            chk("fz_hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
        end
        freeze = 1'b0;
        step();
        chk("fz_rel_pcout", pc_out, 32'd12);
        chk("fz_rel_instr", instruction, 32'd8);
        chk("fz_rel_addr", imem_bus.imem_addr, 32'd12);
        step();
        chk("fz_next_pcout", pc_out, 32'd16);
        chk("fz_next_instr", instruction, 32'd12);

        // Branch while a 2-wait fetch of 0x10 is outstanding
        do_reset(0);
        repeat (4) step();
        chk("br_pre_pcout", pc_out, 32'h10);
        chk("br_pre_addr", imem_bus.imem_addr, 32'h10);
        mem_wait = 2;
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("br_flush_valid", {31'd0, valid}, 32'd0);
        chk("br_flush_pcout", pc_out, 32'd0);
        chk("br_drop_addr", imem_bus.imem_addr, 32'h10);
        chk("br_drop_req", {31'd0, imem_bus.imem_req}, 32'd1);
        chk("br_drop_state", {30'd0, dbg_state}, 32'd2);
        step();
        chk("br_drop2_addr", imem_bus.imem_addr, 32'h10);
        chk("br_drop2_valid", {31'd0, valid}, 32'd0);
        step();
        chk("br_discard_valid", {31'd0, valid}, 32'd0);
        chk("br_new_addr", imem_bus.imem_addr, 32'h100);
        begin
            int n;
            n = 0;
            while (!valid && n < 8) begin
                step();
                n++;
            end
            chk("br_first_valid", {31'd0, valid}, 32'd1);
            chk("br_first_pcout", pc_out, 32'h104);
            chk("br_first_instr", instruction, 32'h100);
        end

        // Branch and freeze together in S_HOLD
        do_reset(0);
        freeze = 1'b1;
        step();
        chk("hb_hold_state", {30'd0, dbg_state}, 32'd1);
        chk("hb_hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        step();
        freeze = 1'b0;
        branch_taken = 1'b0;
        chk("hb_flush_valid", {31'd0, valid}, 32'd0);
        chk("hb_addr", imem_bus.imem_addr, 32'h40);
        step();
        chk("hb_pcout", pc_out, 32'h44);
        chk("hb_instr", instruction, 32'h40);

        // PC wraps modulo 2^32
        do_reset(0);
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("wr_flush_valid", {31'd0, valid}, 32'd0);
        chk("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wr_instr", instruction, 32'hFFFF_FFFC);
        chk("wr_pcout", pc_out, 32'd0);
        chk("wr_next_addr", imem_bus.imem_addr, 32'd0);

        // Second branch in S_DROP wins, then reset mid-request
        do_reset(2);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        branch_addr  = 32'h200;
        step();
        branch_taken = 1'b0;
        chk("db_still_old", imem_bus.imem_addr, 32'd0);
        step();
        chk("db_addr", imem_bus.imem_addr, 32'h200);
        chk("db_state", {30'd0, dbg_state}, 32'd0);
        mem_wait = 0;
        step();
        chk("db_pcout", pc_out, 32'h204);
        chk("db_valid", {31'd0, valid}, 32'd1);
        mem_wait = 2;
        #1;
        chk("db_pending_req", {31'd0, imem_bus.imem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mr_valid", {31'd0, valid}, 32'd0);
        chk("mr_instr", instruction, 32'd0);
        chk("mr_pcout", pc_out, 32'd0);
        chk("mr_req", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("mr_addr", imem_bus.imem_addr, 32'd0);
        chk("mr_req_after", {31'd0, imem_bus.imem_req}, 32'd1);
        repeat (3) step();
        chk("mr_first_valid", {31'd0, valid}, 32'd1);
        chk("mr_first_pcout", pc_out, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
